// File: rtl/fpga_bringup_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpga_bringup_sequencer_if
// Bus bundle between the bring-up sequencer and the loader, soft CPU and
// program RAM.
//   Loader : ld_load (seq->ld), ld_addr/ld_we/ld_data/ld_done (ld->seq)
//   CPU    : cpu_reset/cpu_rdy/cpu_di (seq->cpu), cpu_do/cpu_we/cpu_lh (cpu->seq)
//   RAM    : ram_addr/ram_we/ram_re/ram_din (seq->ram), ram_dout (ram->seq)
// The master modport is the sequencer; slave is the environment side.
// ---------------------------------------------------------------------------
interface fpga_bringup_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              ld_load;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_we;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;

    logic              cpu_reset;
    logic              cpu_rdy;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_we;
    logic [2:0]        cpu_lh;
    logic [DATA_W-1:0] cpu_di;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ld_load,
        input  ld_addr, ld_we, ld_data, ld_done,
        output cpu_reset, cpu_rdy, cpu_di,
        input  cpu_do, cpu_we, cpu_lh,
        output ram_addr, ram_we, ram_re, ram_din,
        input  ram_dout
    );

    modport slave (
        input  ld_load,
        output ld_addr, ld_we, ld_data, ld_done,
        input  cpu_reset, cpu_rdy, cpu_di,
        output cpu_do, cpu_we, cpu_lh,
        input  ram_addr, ram_we, ram_re, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/fpga_bringup_sequencer.sv
// ---------------------------------------------------------------------------
// fpga_bringup_sequencer
// Brings a soft CPU up from power-on: holds it in reset, lets the loader fill
// program RAM, waits a settle interval, runs the CPU against RAM until it
// writes the halt mailbox or exhausts its cycle budget, then exposes a small
// result window one word at a time under a step button.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          run enable level; dropping it returns to IDLE
//   step           button level; rising edge advances the dump index in DUMP
//   bus            loader / CPU / RAM bundle (master side)
//   disp_data      registered RAM word at DUMP_BASE+disp_idx
//   disp_idx       current dump index
//   halted,timeout why RUN ended
//   state          FSM state (IDLE=0 RESET=1 LOAD=2 SETTLE=3 RUN=4 DUMP=5)
// ---------------------------------------------------------------------------
module fpga_bringup_sequencer #(
    parameter int          ADDR_W        = 16,
    parameter int          DATA_W        = 8,
    parameter int          RESET_CYCLES  = 8,
    parameter int          SETTLE_CYCLES = 6,
    parameter int          RUN_BUDGET    = 2444,
    parameter int unsigned DUMP_BASE     = 32'hE200,
    parameter int          DUMP_LEN      = 4,
    parameter int unsigned MAILBOX_ADDR  = 32'hFFF0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      step,
    fpga_bringup_sequencer_if.master  bus,
    output logic [DATA_W-1:0]         disp_data,
    output logic [7:0]                disp_idx,
    output logic                      halted,
    output logic                      timeout,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DUMP   = 3'd5
    } state_t;

    localparam logic [31:0]       RESET_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]       SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]       RUN_LAST    = 32'(RUN_BUDGET - 1);
    localparam logic [7:0]        IDX_LAST    = 8'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] MBOX        = ADDR_W'(MAILBOX_ADDR);
    localparam logic [ADDR_W-1:0] DBASE       = ADDR_W'(DUMP_BASE);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_cnt;
    logic [DATA_W-1:0]   r_addr_lo;
    logic [DATA_W-1:0]   r_addr_hi;
    logic [DATA_W-1:0]   r_disp_data;
    logic [7:0]          r_disp_idx;
    logic                r_halted;
    logic                r_timeout;
    logic                r_step_d;

    logic [ADDR_W-1:0]   w_cpu_addr;
    logic                w_run_we;
    logic                w_run_re;
    logic                w_mbox_hit;
    logic                w_step_rise;
    logic                w_halt_set;
    logic                w_tmo_set;

    // CPU address is serialized a byte at a time; cpu_lh tells which phase.
    assign w_cpu_addr  = ADDR_W'({r_addr_hi, r_addr_lo});
    assign w_run_we    = bus.cpu_we & (bus.cpu_lh == 3'd5);
    assign w_run_re    = ~w_run_we & (bus.cpu_lh == 3'd3);
    assign w_mbox_hit  = w_run_we && (w_cpu_addr == MBOX) && (bus.cpu_do != '0);
    assign w_step_rise = step & ~r_step_d;

    assign bus.cpu_di = bus.ram_dout;
    assign disp_data  = r_disp_data;
    assign disp_idx   = r_disp_idx;
    assign halted     = r_halted;
    assign timeout    = r_timeout;
    assign state      = r_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and all bus outputs, decoded from the current state so an
    // asynchronous reset removes any RAM write strobe immediately.
    always_comb begin
        w_next        = r_state;
        w_halt_set    = 1'b0;
        w_tmo_set     = 1'b0;
        bus.ld_load   = 1'b0;
        bus.cpu_reset = 1'b1;
        bus.cpu_rdy   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_re    = 1'b0;
        bus.ram_din   = '0;

        case (r_state)
            S_IDLE: begin
                w_next = S_RESET;
            end
            S_RESET: begin
                if (r_cnt == RESET_LAST) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.ld_load  = 1'b1;
                bus.ram_addr = bus.ld_addr;
                bus.ram_we   = bus.ld_we;
                bus.ram_din  = bus.ld_data;
                if (bus.ld_done) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                bus.cpu_reset = 1'b0;
                if (r_cnt == SETTLE_LAST) w_next = S_RUN;
            end
            S_RUN: begin
                bus.cpu_reset = 1'b0;
                bus.cpu_rdy   = 1'b1;
                bus.ram_addr  = w_cpu_addr;
                bus.ram_we    = w_run_we;
                bus.ram_re    = w_run_re;
                bus.ram_din   = bus.cpu_do;
                // A mailbox halt wins over budget expiry in the same cycle.
                if (w_mbox_hit) begin
                    w_next     = S_DUMP;
                    w_halt_set = 1'b1;
                end else if (r_cnt == RUN_LAST) begin
                    w_next    = S_DUMP;
                    w_tmo_set = 1'b1;
                end
            end
            S_DUMP: begin
                bus.cpu_reset = 1'b0;
                bus.ram_re    = 1'b1;
                bus.ram_addr  = DBASE + ADDR_W'(r_disp_idx);
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (!start) w_next = S_IDLE;
    end

    // Phase counter: restarts on every state change, runs only in timed states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_RESET || r_state == S_SETTLE || r_state == S_RUN) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Address byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_lo <= '0;
            r_addr_hi <= '0;
        end else if (r_state == S_RESET) begin
            r_addr_lo <= '0;
            r_addr_hi <= '0;
        end else if (r_state != S_IDLE) begin
            if (bus.cpu_lh == 3'd0) r_addr_lo <= bus.cpu_do;
            if (bus.cpu_lh == 3'd2) r_addr_hi <= bus.cpu_do;
        end
    end

    // Status flags and dump index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
            r_disp_idx <= '0;
            r_step_d   <= 1'b0;
        end else begin
            r_step_d <= step;
            if (!start) begin
                r_halted   <= 1'b0;
                r_timeout  <= 1'b0;
                r_disp_idx <= '0;
            end else begin
                if (w_halt_set) r_halted  <= 1'b1;
                if (w_tmo_set)  r_timeout <= 1'b1;
                if (r_state == S_DUMP && w_step_rise) begin
                    r_disp_idx <= (r_disp_idx == IDX_LAST) ? 8'd0 : r_disp_idx + 8'd1;
                end
            end
        end
    end

    // Dump display register: RAM read data lands one cycle after the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_data <= '0;
        end else if (r_state == S_DUMP) begin
            r_disp_data <= bus.ram_dout;
        end
    end

endmodule
